// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_ctrl_pkg
//  Description : Shared types and helpers for the binarised conv layer
//                sequencer: FSM state encoding, fold address width rule and
//                the number of priming pixels ahead of the first window.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACT   = 3'd1,
        ST_FOLD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Address width for the fold-indexed memories; never narrower than 1 bit
    // so a single-fold layer still has a real (constant 0) address port.
    function automatic int fold_log_f(input int fold);
        int l;
        l = $clog2(fold);
        return (l < 1) ? 1 : l;
    endfunction

    // Pixels that must enter the line buffer before the first full window.
    function automatic int prime_f(input int pad, input int w_in);
        return pad * w_in + pad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fold_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fold_addr_counter
//  Description : Modulo-MODULUS up counter. Advances on i_en and wraps from
//                MODULUS-1 back to 0; o_last flags the terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module fold_addr_counter #(
    parameter int MODULUS = 1,
    parameter int WIDTH   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == c_LAST);

    // Count enabled events, wrapping at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : (r_cnt + c_ONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_ctrl
//  Description : Sequencer for one binarised convolution layer. Loads the
//                fold weight/threshold memories, accepts a frame of pixels,
//                and per window drives the fold sweep and max-pool enable.
//                Optional macro CONV_CTRL_PERF_EN adds a busy-cycle counter
//                on port perf_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int FOLD = 1,
    parameter int W_IN = 32,
    parameter int K_S  = 3,
    parameter int PAD  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic                          cfg_w_valid,
    input  logic                          cfg_th_valid,
    output logic                          cfg_loaded,
    output logic                          stream_w_en,
    output logic                          stream_th_en,
    output logic [fold_log_f(FOLD)-1:0]   stream_w_addr,
    output logic [fold_log_f(FOLD)-1:0]   stream_th_addr,
    input  logic                          act_valid,
    output logic                          act_ready,
    output logic                          act_zero,
    output logic                          stream_act_en,
    output logic [fold_log_f(FOLD)-1:0]   fold_add,
    output logic                          stream_maxpool_en
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int c_FL     = fold_log_f(FOLD);
    localparam int c_NPIX   = W_IN * W_IN;
    localparam int c_PRIME  = prime_f(PAD, W_IN);
    // Pixel counter spans input pixels plus flush pixels.
    localparam int c_PCNT_W = $clog2(c_NPIX + c_PRIME + 1);
    localparam int c_WIN_W  = $clog2(c_NPIX + 1);

    localparam logic [c_PCNT_W-1:0] c_PRIME_P   = c_PCNT_W'(c_PRIME);
    localparam logic [c_PCNT_W-1:0] c_NPIX_P    = c_PCNT_W'(c_NPIX);
    localparam logic [c_PCNT_W-1:0] c_LASTPIX_P = c_PCNT_W'(c_NPIX - 1);
    localparam logic [c_PCNT_W-1:0] c_PCNT_ONE  = c_PCNT_W'(1);
    localparam logic [c_WIN_W-1:0]  c_LASTWIN   = c_WIN_W'(c_NPIX - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_ONE   = c_WIN_W'(1);
    // A kernel that cannot cover its own padding is a broken build; such a
    // layer never leaves IDLE rather than producing garbage windows.
    localparam logic                c_CFG_OK    = (K_S >= 1) && (2 * PAD < K_S);

    state_t              r_state;
    logic [c_PCNT_W-1:0] r_pcnt;
    logic [c_WIN_W-1:0]  r_win;
    logic                r_maxpool;
    logic                r_done;
    logic                r_w_pass;
    logic                r_th_pass;

    logic                w_idle;
    logic                w_frame_go;
    logic                w_in_fold;
    logic                w_fold_last;
    logic                w_fold_done;
    logic                w_w_last;
    logic                w_th_last;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_frame_go = w_idle && start && cfg_loaded && c_CFG_OK;
    assign w_in_fold  = (r_state == ST_FOLD);
    assign w_fold_done = w_in_fold && w_fold_last;

    // ---------------- configuration load ----------------
    assign stream_w_en  = cfg_w_valid  && w_idle && !reset;
    assign stream_th_en = cfg_th_valid && w_idle && !reset;
    assign cfg_loaded   = r_w_pass && r_th_pass;

    fold_addr_counter #(.MODULUS(FOLD), .WIDTH(c_FL)) u_w_addr (
        .clk    (clk),
        .rst    (reset),
        .i_en   (stream_w_en),
        .o_cnt  (stream_w_addr),
        .o_last (w_w_last)
    );

    fold_addr_counter #(.MODULUS(FOLD), .WIDTH(c_FL)) u_th_addr (
        .clk    (clk),
        .rst    (reset),
        .i_en   (stream_th_en),
        .o_cnt  (stream_th_addr),
        .o_last (w_th_last)
    );

    // Latch completion of the first full pass through each memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_pass  <= 1'b0;
            r_th_pass <= 1'b0;
        end else begin
            if (stream_w_en && w_w_last) begin
                r_w_pass <= 1'b1;
            end
            if (stream_th_en && w_th_last) begin
                r_th_pass <= 1'b1;
            end
        end
    end

    // ---------------- fold sweep ----------------
    // Runs only in FOLD and wraps on the last fold, so it is back at 0
    // whenever a new window's sweep begins.
    fold_addr_counter #(.MODULUS(FOLD), .WIDTH(c_FL)) u_fold (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_in_fold),
        .o_cnt  (fold_add),
        .o_last (w_fold_last)
    );

    // ---------------- pixel handshake / flags ----------------
    assign busy              = !w_idle;
    assign act_ready         = (r_state == ST_ACT);
    assign act_zero          = (r_state == ST_FLUSH);
    assign stream_act_en     = (act_ready && act_valid) || act_zero;
    assign stream_maxpool_en = r_maxpool;
    assign done              = r_done;

    // Frame sequencer: pixel intake, per-window fold sweep, zero flush, finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pcnt    <= '0;
            r_win     <= '0;
            r_maxpool <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_maxpool <= w_fold_done;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_go) begin
                        r_state <= ST_ACT;
                        r_pcnt  <= '0;
                        r_win   <= '0;
                    end
                end
                ST_ACT: begin
                    if (act_valid) begin
                        r_pcnt <= r_pcnt + c_PCNT_ONE;
                        if (r_pcnt >= c_PRIME_P) begin
                            r_state <= ST_FOLD;
                        end else if (r_pcnt == c_LASTPIX_P) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FOLD: begin
                    if (w_fold_last) begin
                        r_win <= r_win + c_WIN_ONE;
                        if (r_win == c_LASTWIN) begin
                            r_state <= ST_FIN;
                        end else if (r_pcnt >= c_NPIX_P) begin
                            r_state <= ST_FLUSH;
                        end else begin
                            r_state <= ST_ACT;
                        end
                    end
                end
                ST_FLUSH: begin
                    // A zero pixel that still lands in the priming region
                    // produces no window (only for very small frames).
                    r_pcnt <= r_pcnt + c_PCNT_ONE;
                    if (r_pcnt >= c_PRIME_P) begin
                        r_state <= ST_FOLD;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Busy-cycle counter, restarted at each frame launch and held after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf <= '0;
        end else if (w_frame_go) begin
            r_perf <= '0;
        end else if (busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_ctrl
//  Description : Self-checking bench for conv_layer_ctrl. Two instances:
//                dut 0 (fold=2, w_in=4) and dut 1 (fold=1, w_in=2). A frame
//                schedule model predicts every output per frame cycle.
//                Honours CONV_CTRL_PERF_EN for the perf_cycles checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_ctrl;

    typedef struct packed {
        logic busy;
        logic ready;
        logic zero;
        logic act_en;
        logic fadd;
        logic mp;
        logic done;
    } exp_t;

    logic clk;
    logic reset;

    logic       start_i  [2];
    logic       cfgw_i   [2];
    logic       cfgth_i  [2];
    logic       av_i     [2];
    logic       busy_o   [2];
    logic       done_o   [2];
    logic       loaded_o [2];
    logic       wen_o    [2];
    logic       then_o   [2];
    logic       ready_o  [2];
    logic       zero_o   [2];
    logic       aen_o    [2];
    logic       mp_o     [2];
    logic [0:0] waddr_o  [2];
    logic [0:0] thaddr_o [2];
    logic [0:0] fadd_o   [2];
`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_o  [2];
`endif

    conv_layer_ctrl #(.FOLD(2), .W_IN(4), .K_S(3), .PAD(1)) u_dut0 (
        .clk               (clk),
        .reset             (reset),
        .start             (start_i[0]),
        .busy              (busy_o[0]),
        .done              (done_o[0]),
        .cfg_w_valid       (cfgw_i[0]),
        .cfg_th_valid      (cfgth_i[0]),
        .cfg_loaded        (loaded_o[0]),
        .stream_w_en       (wen_o[0]),
        .stream_th_en      (then_o[0]),
        .stream_w_addr     (waddr_o[0]),
        .stream_th_addr    (thaddr_o[0]),
        .act_valid         (av_i[0]),
        .act_ready         (ready_o[0]),
        .act_zero          (zero_o[0]),
        .stream_act_en     (aen_o[0]),
        .fold_add          (fadd_o[0]),
        .stream_maxpool_en (mp_o[0])
`ifdef CONV_CTRL_PERF_EN
        ,
        .perf_cycles       (perf_o[0])
`endif
    );

    conv_layer_ctrl #(.FOLD(1), .W_IN(2), .K_S(3), .PAD(1)) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .start             (start_i[1]),
        .busy              (busy_o[1]),
        .done              (done_o[1]),
        .cfg_w_valid       (cfgw_i[1]),
        .cfg_th_valid      (cfgth_i[1]),
        .cfg_loaded        (loaded_o[1]),
        .stream_w_en       (wen_o[1]),
        .stream_th_en      (then_o[1]),
        .stream_w_addr     (waddr_o[1]),
        .stream_th_addr    (thaddr_o[1]),
        .act_valid         (av_i[1]),
        .act_ready         (ready_o[1]),
        .act_zero          (zero_o[1]),
        .stream_act_en     (aen_o[1]),
        .fold_add          (fadd_o[1]),
        .stream_maxpool_en (mp_o[1])
`ifdef CONV_CTRL_PERF_EN
        ,
        .perf_cycles       (perf_o[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    exp_t exp_q [$];
    bit   chk_on;
    int   cur_dut;
    int   cur_t;
    int   seen_mp, seen_done, seen_in_en, seen_zero_en, seen_stall_en;
    int   m_t;
    bit   m_mp_next;

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    function automatic exp_t sample(input int d);
        exp_t s;
        s.busy   = busy_o[d];
        s.ready  = ready_o[d];
        s.zero   = zero_o[d];
        s.act_en = aen_o[d];
        s.fadd   = fadd_o[d][0];
        s.mp     = mp_o[d];
        s.done   = done_o[d];
        return s;
    endfunction

    function automatic bit valid_at(input int mode, input int t);
        return (mode == 0) ? 1'b1 : ((t % 2) == 0);
    endfunction

    // ---------------- frame schedule model ----------------
    task automatic m_push(input bit busy, input bit rdy, input bit zero,
                          input bit aen, input bit fadd, input bit done);
        exp_t e;
        e.busy = busy; e.ready = rdy; e.zero = zero; e.act_en = aen;
        e.fadd = fadd; e.done = done;
        e.mp = m_mp_next;
        m_mp_next = 1'b0;
        exp_q.push_back(e);
        m_t++;
    endtask

    // Pixel q (input pixels first, then zero flush pixels) yields a window
    // once q >= prime; each window is a fold sweep and one max-pool pulse on
    // the following cycle. Input pixels wait out cycles with act_valid low.
    task automatic build_model(input int fold, input int npix, input int prime, input int mode);
        exp_q.delete();
        m_t = 0;
        m_mp_next = 1'b0;
        for (int q = 0; q < npix + prime; q++) begin
            if (q < npix) begin
                while (!valid_at(mode, m_t)) m_push(1, 1, 0, 0, 0, 0);
                m_push(1, 1, 0, 1, 0, 0);
            end else begin
                m_push(1, 0, 1, 1, 0, 0);
            end
            if (q >= prime) begin
                for (int f = 0; f < fold; f++) m_push(1, 0, 0, 0, f[0], 0);
                m_mp_next = 1'b1;
            end
        end
        m_push(1, 0, 0, 0, 0, 0);
        m_push(0, 0, 0, 0, 0, 1);
    endtask

    task automatic model_stats(output int last_mp, output int done_idx,
                               output int n_in, output int n_zero, output int n_busy);
        last_mp = -1; done_idx = -1; n_in = 0; n_zero = 0; n_busy = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].mp) last_mp = i;
            if (exp_q[i].done) done_idx = i;
            if (exp_q[i].act_en && !exp_q[i].zero) n_in++;
            if (exp_q[i].act_en && exp_q[i].zero) n_zero++;
            if (exp_q[i].busy) n_busy++;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                exp_t a;
                exp_t e;
                a = sample(cur_dut);
                e = exp_q[cur_t];
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL frame_vec dut%0d t=%0d: got %b expected %b (busy,rdy,zero,act_en,fadd,mp,done)",
                             cur_dut, cur_t, a, e);
                end
                if (a.mp) seen_mp++;
                if (a.done) seen_done++;
                if (a.act_en && !a.zero) seen_in_en++;
                if (a.act_en && a.zero) seen_zero_en++;
                if (a.act_en && !a.zero && !av_i[cur_dut]) seen_stall_en++;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic run_frame(input int d, input int mode, input int restart_at, input int abort_at);
        seen_mp = 0; seen_done = 0; seen_in_en = 0; seen_zero_en = 0; seen_stall_en = 0;
        @(negedge clk);
        start_i[d] = 1'b1;
        @(posedge clk);
        #1;
        start_i[d] = 1'b0;
        cur_dut = d;
        chk_on = 1'b1;
        for (int t = 0; t < exp_q.size(); t++) begin
            if (t == abort_at) break;
            cur_t = t;
            av_i[d] = valid_at(mode, t);
            start_i[d] = (t == restart_at);
            @(posedge clk);
            #1;
        end
        chk_on = 1'b0;
        av_i[d] = 1'b0;
        start_i[d] = 1'b0;
    endtask

    task automatic cfg_write(input int d, input bit w, input bit th);
        @(negedge clk);
        cfgw_i[d] = w;
        cfgth_i[d] = th;
        #1;
        check("cfg_w_en", int'(wen_o[d]), int'(w));
        check("cfg_th_en", int'(then_o[d]), int'(th));
        @(posedge clk);
        #1;
        cfgw_i[d] = 1'b0;
        cfgth_i[d] = 1'b0;
    endtask

    task automatic check_quiet();
        for (int d = 0; d < 2; d++) begin
            check("rst_frame_outs", int'(sample(d)), 0);
            check("rst_cfg_outs", int'({loaded_o[d], wen_o[d], then_o[d], waddr_o[d], thaddr_o[d]}), 0);
`ifdef CONV_CTRL_PERF_EN
            check("rst_perf", int'(perf_o[d]), 0);
`endif
        end
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet();
        end
        reset = 1'b0;
    endtask

    int last_mp, done_idx, n_in, n_zero, n_busy;

    initial begin
        n_checks = 0; n_fail = 0; chk_on = 1'b0; cur_dut = 0; cur_t = 0;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0; cfgw_i[d] = 1'b0; cfgth_i[d] = 1'b0; av_i[d] = 1'b0;
        end

        // Power-up reset.
        hold_reset();

        // Config load, fold=2: 2 weights + 1 threshold leaves cfg_loaded low.
        cfg_write(0, 1, 0);
        cfg_write(0, 1, 0);
        cfg_write(0, 0, 1);
        @(negedge clk);
        check("cfg_loaded_partial", int'(loaded_o[0]), 0);
        check("w_addr_wrapped", int'(waddr_o[0]), 0);
        check("th_addr_mid", int'(thaddr_o[0]), 1);
        cfg_write(0, 0, 1);
        @(negedge clk);
        check("cfg_loaded_full", int'(loaded_o[0]), 1);
        check("th_addr_wrapped", int'(thaddr_o[0]), 0);
        // fold=1 instance: one write each completes a pass.
        cfg_write(1, 1, 1);
        @(negedge clk);
        check("cfg_loaded_fold1", int'(loaded_o[1]), 1);

        // Full frame, no stalls.
        build_model(2, 16, 5, 0);
        model_stats(last_mp, done_idx, n_in, n_zero, n_busy);
        check("model_last_mp", last_mp, 53);
        check("model_done", done_idx, 54);
        check("model_in_en", n_in, 16);
        check("model_zero_en", n_zero, 5);
        run_frame(0, 0, -1, -1);
        check("nostall_mp_pulses", seen_mp, 16);
        check("nostall_done", seen_done, 1);
        check("nostall_in_en", seen_in_en, 16);
        check("nostall_zero_en", seen_zero_en, 5);

        // Stalls: act_valid toggles 1,0.
        build_model(2, 16, 5, 1);
        run_frame(0, 1, -1, -1);
        check("stall_mp_pulses", seen_mp, 16);
        check("stall_in_en", seen_in_en, 16);
        check("stall_zero_en", seen_zero_en, 5);
        check("stall_en_while_invalid", seen_stall_en, 0);
        check("stall_done", seen_done, 1);

        // fold=1, w_in=2, prime=3.
        build_model(1, 4, 3, 0);
        model_stats(last_mp, done_idx, n_in, n_zero, n_busy);
        check("model_f1_last_mp", last_mp, 11);
        check("model_f1_done", done_idx, 12);
        run_frame(1, 0, -1, -1);
        check("fold1_mp_pulses", seen_mp, 4);
        check("fold1_zero_en", seen_zero_en, 3);
        check("fold1_done", seen_done, 1);

        // start during FOLD (frame cycle 6) must not restart the frame.
        build_model(2, 16, 5, 0);
        model_stats(last_mp, done_idx, n_in, n_zero, n_busy);
        check("model_busy_cycles", n_busy, 54);
        run_frame(0, 0, 6, -1);
        check("restart_done", seen_done, 1);
`ifdef CONV_CTRL_PERF_EN
        check("perf_cycles", int'(perf_o[0]), n_busy);
`endif

        // Reset mid-frame aborts; start afterwards is ignored until reload.
        build_model(2, 16, 5, 0);
        run_frame(0, 0, -1, 20);
        hold_reset();
        @(negedge clk);
        start_i[0] = 1'b1;
        @(posedge clk);
        #1;
        start_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_after_reset_busy", int'(busy_o[0]), 0);
            check("start_after_reset_done", int'(done_o[0]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Sequencer for one binarised convolution layer. It loads the per-fold weight and threshold memories and accepts a frame of activation pixels through a valid/ready handshake. For each pixel it drives the layer's buffer shift, fold-address sweep and max-pool enable. It sits between the frame source / config loader and one conv layer instance, and emits a done pulse per frame.

## Interface
- `fold`, 1: number of output-channel folds; `fold_log` = max(1, clog2(fold))
- `w_in`, 32: feature-map width = height (pixels per frame = w_in*w_in)
- `k_s`, 3: conv kernel size
- `pad`, 1: zero padding; `prime` = pad*w_in + pad pixels precede the first window
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a frame (honoured only in IDLE with cfg_loaded=1)
- `busy` out 1: high outside IDLE
- `done` out 1: one-cycle pulse at frame end
- `cfg_w_valid` in 1: weight word present on the layer's stream_w bus
- `cfg_th_valid` in 1: threshold word present on the layer's stream_th bus
- `cfg_loaded` out 1: fold weight and fold threshold writes received
- `stream_w_en`, `stream_th_en` out 1: layer memory write enables
- `stream_w_addr`, `stream_th_addr` out fold_log: write addresses
- `act_valid` in 1, `act_ready` out 1: pixel handshake
- `act_zero` out 1: datapath substitutes an all-zero pixel (flush)
- `stream_act_en` out 1: shift input buffer
- `fold_add` out fold_log: fold selector
- `stream_maxpool_en` out 1: one completed output pixel into max-pool
- `perf_cycles` out 32: only with CONV_CTRL_PERF_EN

## Operation
- **States:** IDLE, ACT, FOLD, FLUSH, FIN.
- **Config loading:** accepted only in IDLE; ignored elsewhere.
  - stream_w_en = cfg_w_valid. stream_w_addr increments after each write and wraps fold-1→0.
  - Threshold path is identical with its own counter.
  - cfg_loaded sets when both counters have completed at least one full pass. It clears on reset only.
- **IDLE→ACT:** on start && cfg_loaded. The pixel counter p and window counter are cleared.
- **ACT:** act_ready=1. stream_act_en = act_valid && act_ready (combinational).
  - On accept, p increments.
  - If p (before increment) >= prime, go to FOLD.
  - Else stay in ACT. After the last pixel (p = w_in*w_in-1) go to FLUSH instead.
- **FOLD:** fold cycles; fold_add = 0,1,…,fold-1; act_ready=0.
  - After the last fold cycle, return to ACT, or to FLUSH when all pixels are accepted and flush is pending.
  - After the final window, go to FIN.
- **FLUSH:** issue prime zero pixels, one cycle each, with stream_act_en=1 and act_zero=1. Each is followed by FOLD.
- **FIN:** done=1 for one cycle → IDLE.
- **Window count:** every frame yields exactly w_in*w_in windows and w_in*w_in stream_maxpool_en pulses.
- **fold=1:** FOLD lasts one cycle and fold_add is constant 0.
- **Reset:** all outputs 0, state IDLE, counters 0, cfg_loaded 0. Reset mid-frame aborts the frame with no done.
- **start while busy:** ignored.

## Timing
- stream_act_en is the same cycle as the handshake; the first FOLD cycle is the next cycle.
- stream_maxpool_en is registered: it pulses exactly one cycle after each window's last FOLD cycle, overlapping whatever state follows.
- done is one cycle after the final stream_maxpool_en.
- act_valid low in ACT causes a stall with no outputs asserted.

## Configuration
- **CONV_CTRL_PERF_EN defined:**
  - perf_cycles counts cycles with busy=1.
  - It clears on the IDLE→ACT transition and holds its value after done.
  - It resets to 0.
- **CONV_CTRL_PERF_EN not defined:** perf_cycles port and counter absent.

## Structure
- The shared package `conv_ctrl_pkg` holds:
  - the state enum
  - a helper function computing fold_log with the max(1, …) rule
  - the prime formula
- One sub-module: `fold_addr_counter`, a wrap-around counter reused for stream_w_addr, stream_th_addr and fold_add.

## Test plan
- **Reset:** reset held 3 cycles mid-frame → all outputs 0, busy 0, cfg_loaded 0; a subsequent start is ignored until reloaded.
- **Config load:** fold=2, 2 weight writes and 1 threshold write → cfg_loaded stays 0; one more threshold write → cfg_loaded=1, addresses wrapped to 0.
- **Full frame, no stalls:** w_in=4, k_s=3, pad=1, fold=2, act_valid always 1 (first accept = cycle 0).
  - 16 stream_act_en from input plus 5 with act_zero.
  - 16 maxpool pulses, the last at cycle 53.
  - done at cycle 54.
- **Stalls:** same config with act_valid toggling 1,0 → same pulse counts; no stream_act_en while act_valid=0.
- **fold=1:** w_in=2, pad=1, k_s=3, prime=3 → fold_add always 0; 4 maxpool pulses, each one cycle after a 1-cycle FOLD.
- **Ignored start:** start asserted during FOLD → no restart; perf_cycles (macro on) equals cycles from start to done.
